// File: rtl/lsu_ctrl.sv
// Load/store sequencer: decodes width/alignment, runs a req/ack memory
// transaction with byte lanes, stalls the core and formats load data.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned   CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;
  logic [1:0]    off_q;
  logic [2:0]    func3_q;

  logic          mem_op, illegal, misaligned, issue;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;

  // Instruction decode; misalignment is only meaningful once legality passes.
  always_comb begin
    mem_op     = rd_en_i | wr_en_i;
    illegal    = (rd_en_i & wr_en_i)
               | (rd_en_i & ((func3_i == 3'b011) | (func3_i[2:1] == 2'b11)))
               | (wr_en_i & (func3_i >= 3'b011));
    misaligned = ~illegal
               & (((func3_i[1:0] == 2'b01) & addr_i[0])
               |  ((func3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00)));
    issue      = mem_op & ~illegal & ~misaligned;

    case (func3_i[1:0])
      2'b00:   be_calc = 4'b0001 << addr_i[1:0];
      2'b01:   be_calc = addr_i[1] ? 4'b1100 : 4'b0011;
      default: be_calc = 4'b1111;
    endcase

    case (func3_i[1:0])
      2'b00:   wdata_calc = {4{wdata_i[7:0]}};
      2'b01:   wdata_calc = {2{wdata_i[15:0]}};
      default: wdata_calc = wdata_i;
    endcase
  end

  // Lane extraction of the returned word, selected by the captured offset.
  logic [7:0]  lane_b [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_b[gi] = mem_rdata_i[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    byte_sel = lane_b[off_q];
    half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (func3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_fmt = {24'h0, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {16'h0, half_sel};
      default: load_fmt = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    err_o     = 2'b00;
    rdata_o   = 32'h0;
    mem_req_o = 1'b0;
    cnt_inc   = (cnt_q == TO_VAL) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          stall_o = 1'b1;
          cnt_d   = '0;
          state_d = ST_REQ;
        end else if (mem_op) begin
          done_o = 1'b1;
          err_o  = illegal ? 2'b10 : 2'b01;
        end
      end
      ST_REQ: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        // An ack on the expiry cycle still completes the access normally.
        if (mem_ack_i) begin
          state_d = ST_DONE;
          err_d   = 2'b00;
          rdata_d = mem_we_q ? 32'h0 : load_fmt;
        end else if (cnt_inc == TO_VAL) begin
          state_d = ST_DONE;
          err_d   = 2'b11;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        rdata_o = rdata_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= 2'b00;
      rdata_q     <= 32'h0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      off_q       <= 2'b00;
      func3_q     <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if ((state_q == ST_IDLE) && issue) begin
        mem_we_q    <= wr_en_i;
        mem_addr_q  <= {addr_i[31:2], 2'b00};
        mem_be_q    <= be_calc;
        mem_wdata_q <= wdata_calc;
        off_q       <= addr_i[1:0];
        func3_q     <= func3_i;
      end
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset/back-to-back sequences,
// and randomized transactions checked against a rule-level reference model.
module tb_lsu_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        rd_en = 1'b0, wr_en = 1'b0, mem_ack = 1'b0;
  logic [2:0]  func3 = 3'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0, mem_rdata = 32'h0;
  logic        stall_o, done_o, mem_req_o, mem_we_o;
  logic [1:0]  err_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  int checks = 0, failures = 0;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rd_en_i(rd_en), .wr_en_i(wr_en),
    .func3_i(func3), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    int          stalls;
    int          reqs;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } exp_t;

  typedef struct {
    bit          done;
    int          cycles;
    int          stalls;
    int          reqs;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    bit          unstable;
    bit          stall_on_done;
  } obs_t;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd, mrd;
    int          ack;
    exp_t        e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: derived from access size, offset and ack arrival alone.
  function automatic exp_t model(logic rd, logic wr, logic [2:0] f3, logic [31:0] a,
                                 logic [31:0] wd, logic [31:0] mrd, int ack_at);
    exp_t e;
    int size, off, n;
    bit bad_code, mis;
    logic [31:0] v, mask;
    e = '{default: 0};
    bad_code = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3 >= 3);
    size = 1 << f3[1:0];
    off  = int'(a % 4);
    mis  = !bad_code && ((a % size) != 0);
    if (bad_code || mis) begin
      e.cycles = 1;
      e.err    = bad_code ? 2'd2 : 2'd1;
      return e;
    end
    n = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
    e.reqs   = n;
    e.stalls = n + 1;
    e.cycles = n + 2;
    e.err    = (n == ack_at) ? 2'd0 : 2'd3;
    e.we     = wr;
    e.maddr  = a & ~32'h3;
    e.be     = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.mwdata[8*i +: 8] = wd[8*(i % size) +: 8];
    if (rd && e.err == 2'd0) begin
      v    = mrd >> (8 * off);
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 1);
      v    = v & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      e.rdata = v;
    end
    return e;
  endfunction

  // Runs one instruction from posedge+1 until done, acting as the memory.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                       input int ack_at, input bit noise, output obs_t o);
    o = '{default: 0};
    rd_en = rd; wr_en = wr; func3 = f3; addr = a; wdata = wd;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (stall_o) o.stalls++;
      if (mem_req_o) begin
        if (o.reqs > 0 && (mem_be_o !== o.be || mem_we_o !== o.we ||
                           mem_addr_o !== o.maddr || mem_wdata_o !== o.mwdata))
          o.unstable = 1;
        o.reqs++;
        o.be = mem_be_o; o.we = mem_we_o; o.maddr = mem_addr_o; o.mwdata = mem_wdata_o;
        mem_ack   = (o.reqs == ack_at);
        mem_rdata = (o.reqs == ack_at) ? mrd : $urandom;
      end else begin
        mem_ack   = noise ? 1'($urandom) : 1'b0;
        mem_rdata = $urandom;
      end
      if (done_o) begin
        o.done = 1; o.cycles = c; o.err = err_o; o.rdata = rdata_o;
        o.stall_on_done = stall_o;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic check_op(input string tag, input obs_t o, input exp_t e);
    chk({tag, ".done"}, 32'(o.done), 32'd1);
    chk({tag, ".cycles"}, o.cycles, e.cycles);
    chk({tag, ".stalls"}, o.stalls, e.stalls);
    chk({tag, ".reqs"}, o.reqs, e.reqs);
    chk({tag, ".err"}, 32'(o.err), 32'(e.err));
    chk({tag, ".rdata"}, o.rdata, e.rdata);
    chk({tag, ".stall_at_done"}, 32'(o.stall_on_done), 32'd0);
    if (e.reqs > 0) begin
      chk({tag, ".be"}, 32'(o.be), 32'(e.be));
      chk({tag, ".we"}, 32'(o.we), 32'(e.we));
      chk({tag, ".maddr"}, o.maddr, e.maddr);
      chk({tag, ".mwdata"}, o.mwdata, e.mwdata);
      chk({tag, ".stable"}, 32'(o.unstable), 32'd0);
    end
    $display("op %s rd=%0d wr=%0d f3=%0d addr=%h -> err=%0d rdata=%h cycles=%0d",
             tag, rd_en, wr_en, func3, addr, o.err, o.rdata, o.cycles);
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] mrd, int ack,
                              int cyc, int st, int rq, logic [1:0] err, logic [31:0] rdata,
                              logic [3:0] be, logic [31:0] maddr, logic [31:0] mwdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.mrd = mrd; v.ack = ack;
    v.e = '{cycles: cyc, stalls: st, reqs: rq, err: err, rdata: rdata,
            be: be, we: wr, maddr: maddr, mwdata: mwdata};
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    obs_t o;
    exp_t e;
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a, wd, mrd;
    int ack, sel;

    tbl.push_back(mk(1,0,3'd2,32'h100,32'h11223344,32'hDEADBEEF,1, 3,2,1,2'd0,32'hDEADBEEF,4'hF,32'h100,32'h11223344));
    tbl.push_back(mk(1,0,3'd0,32'h103,32'h000000CC,32'h80123456,4, 6,5,4,2'd0,32'hFFFFFF80,4'h8,32'h100,32'hCCCCCCCC));
    tbl.push_back(mk(1,0,3'd4,32'h103,32'h000000CC,32'h80123456,4, 6,5,4,2'd0,32'h00000080,4'h8,32'h100,32'hCCCCCCCC));
    tbl.push_back(mk(0,1,3'd1,32'h202,32'h0000ABCD,32'h0,1,        3,2,1,2'd0,32'h0,4'hC,32'h200,32'hABCDABCD));
    tbl.push_back(mk(0,1,3'd0,32'h201,32'h000000A5,32'h0,2,        4,3,2,2'd0,32'h0,4'h2,32'h200,32'hA5A5A5A5));
    tbl.push_back(mk(1,0,3'd2,32'h102,32'h0,32'h0,1,               1,0,0,2'd1,32'h0,4'h0,32'h0,32'h0));
    tbl.push_back(mk(1,0,3'd3,32'h100,32'h0,32'h0,1,               1,0,0,2'd2,32'h0,4'h0,32'h0,32'h0));
    tbl.push_back(mk(1,1,3'd2,32'h100,32'h0,32'h0,1,               1,0,0,2'd2,32'h0,4'h0,32'h0,32'h0));
    tbl.push_back(mk(1,0,3'd2,32'h300,32'h0,32'h0,0,               6,5,4,2'd3,32'h0,4'hF,32'h300,32'h0));
    tbl.push_back(mk(1,0,3'd2,32'h300,32'h0,32'h12345678,4,        6,5,4,2'd0,32'h12345678,4'hF,32'h300,32'h0));
    tbl.push_back(mk(1,0,3'd1,32'h102,32'h0,32'h80017FFF,1,        3,2,1,2'd0,32'hFFFF8001,4'hC,32'h100,32'h0));
    tbl.push_back(mk(1,0,3'd5,32'h102,32'h0,32'h80017FFF,1,        3,2,1,2'd0,32'h00008001,4'hC,32'h100,32'h0));
    tbl.push_back(mk(1,0,3'd1,32'h100,32'h0,32'h80017FFF,2,        4,3,2,2'd0,32'h00007FFF,4'h3,32'h100,32'h0));
    tbl.push_back(mk(0,1,3'd3,32'h100,32'h0,32'h0,1,               1,0,0,2'd2,32'h0,4'h0,32'h0,32'h0));
    tbl.push_back(mk(0,1,3'd1,32'h201,32'h0,32'h0,1,               1,0,0,2'd1,32'h0,4'h0,32'h0,32'h0));
    tbl.push_back(mk(1,0,3'd2,32'h304,32'h0,32'h55,5,              6,5,4,2'd3,32'h0,4'hF,32'h304,32'h0));

    // Outputs while held in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.stall", 32'(stall_o), 32'd0);
    chk("reset.done", 32'(done_o), 32'd0);
    chk("reset.err", 32'(err_o), 32'd0);
    chk("reset.rdata", rdata_o, 32'd0);
    chk("reset.mem_req", 32'(mem_req_o), 32'd0);
    chk("reset.mem_we", 32'(mem_we_o), 32'd0);
    chk("reset.mem_addr", mem_addr_o, 32'd0);
    chk("reset.mem_be", 32'(mem_be_o), 32'd0);
    chk("reset.mem_wdata", mem_wdata_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      do_op(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].mrd, tbl[i].ack, 1'b0, o);
      check_op($sformatf("vec%0d", i), o, tbl[i].e);
    end

    // Reset asserted in the second REQ cycle abandons the transaction
    rd_en = 1'b1; wr_en = 1'b0; func3 = 3'd2; addr = 32'h400;
    @(negedge clk);
    chk("rstmid.issue_stall", 32'(stall_o), 32'd1);
    chk("rstmid.issue_noreq", 32'(mem_req_o), 32'd0);
    @(negedge clk);
    chk("rstmid.req1", 32'(mem_req_o), 32'd1);
    @(negedge clk);
    chk("rstmid.req2", 32'(mem_req_o), 32'd1);
    rst_n = 1'b0; rd_en = 1'b0;
    #1;
    chk("rstmid.req_drop", 32'(mem_req_o), 32'd0);
    chk("rstmid.stall_drop", 32'(stall_o), 32'd0);
    chk("rstmid.done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(1'b1, 1'b0, 3'd2, 32'h404, 32'h0, 32'hCAFEF00D, 1, 1'b0, o);
    check_op("after_reset", o, model(1'b1, 1'b0, 3'd2, 32'h404, 32'h0, 32'hCAFEF00D, 1));

    // Back-to-back LW then SW
    do_op(1'b1, 1'b0, 3'd2, 32'h500, 32'h0, 32'h0BADBEEF, 1, 1'b0, o);
    check_op("b2b_lw", o, model(1'b1, 1'b0, 3'd2, 32'h500, 32'h0, 32'h0BADBEEF, 1));
    do_op(1'b0, 1'b1, 3'd2, 32'h504, 32'h76543210, 32'h0, 1, 1'b0, o);
    check_op("b2b_sw", o, model(1'b0, 1'b1, 3'd2, 32'h504, 32'h76543210, 32'h0, 1));

    // Randomized transactions with stray acks outside REQ
    for (int k = 0; k < 200; k++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel <= 4) || (sel == 9);
      wr  = (sel >= 5);
      if ($urandom_range(0, 3) != 0) begin
        if (wr && !rd) f3 = 3'($urandom_range(0, 2));
        else begin
          sel = $urandom_range(0, 4);
          f3  = (sel <= 2) ? 3'(sel) : 3'(sel + 1);
        end
      end else f3 = 3'($urandom_range(0, 7));
      a   = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd  = $urandom;
      mrd = $urandom;
      ack = $urandom_range(0, 6);
      e = model(rd, wr, f3, a, wd, mrd, ack);
      do_op(rd, wr, f3, a, wd, mrd, ack, 1'b1, o);
      check_op($sformatf("rnd%0d", k), o, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the core's single-cycle datapath and a variable-latency data memory. It takes the `rd_en`/`wr_en`/`func3`/address/store data of the current instruction and runs a request/acknowledge transaction with byte lanes and alignment. It stalls the PC and register write-back until the access completes, then returns sign- or zero-extended load data to the write-back mux. It also detects misaligned accesses, illegal width codes and memory timeouts.

## Interface
- `TIMEOUT`, default 255: maximum cycles in REQ without `mem_ack` before abort; legal range 1..65535.
- `clk` input 1: system clock, all state on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rd_en` input 1: load instruction in the current cycle (from control unit).
- `wr_en` input 1: store instruction in the current cycle.
- `func3` input 3: access width/sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
- `addr` input 32: effective byte address from the ALU.
- `wdata` input 32: store data (rs2).
- `stall` output 1: freeze PC and suppress `reg_wr` this cycle.
- `done` output 1: one-cycle pulse; the memory instruction retires this cycle.
- `err` output 2: valid with `done`. 00 ok, 01 misaligned, 10 illegal, 11 bus timeout.
- `rdata` output 32: extended load data, valid with `done`.
- `mem_req` output 1: request, held until acknowledged.
- `mem_we` output 1: 1 = write.
- `mem_addr` output 32: word address (`addr[31:2]`, `2'b00`).
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_ack` input 1: memory completes the request this cycle.
- `mem_rdata` input 32: read word, valid with `mem_ack`.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- **IDLE, issue:** `rd_en` xor `wr_en`, legal `func3`, aligned address.
  - Register `mem_addr`, `mem_we`, `mem_be` and `mem_wdata`, plus `addr[1:0]` and `func3` for load formatting.
  - Clear the timeout counter.
  - `stall`=1 combinationally.
  - Go to REQ.
- **IDLE, error:** memory op requested but illegal or misaligned.
  - No memory request is issued.
  - `done`=1, `stall`=0, `rdata`=0.
  - `err`=10 (illegal) or 01 (misaligned); stay in IDLE.
- **Illegal conditions:**
  - `rd_en` and `wr_en` both 1.
  - Load `func3` in {011, 110, 111}.
  - Store `func3` >= 011.
- **Misaligned conditions** (checked only after legality passes):
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠00.
- **REQ:**
  - `mem_req`=1, `stall`=1; all `mem_*` outputs held stable.
  - On `mem_ack`: capture `mem_rdata` (loads), go to DONE with err 00.
  - Counter increments each REQ cycle without ack. On reaching `TIMEOUT`, go to DONE with err 11 and captured data 0.
- **DONE:** `stall`=0, `done`=1, `rdata` driven from the captured word; next state IDLE unconditionally. A memory op present in the following IDLE cycle is a new instruction.
- **Byte enables:**
  - Byte: `mem_be` = 0001 << `addr[1:0]`.
  - Half: 0011, or 1100 when `addr[1]`=1.
  - Word: 1111.
- **Store data:** byte replicated ×4, half ×2, word as is.
- **Load formatting:** select the lane by stored `addr[1:0]`. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. Stores return `rdata`=0.
- No memory op and state IDLE: all outputs 0 except held `mem_*` registers, which are don't-care while `mem_req`=0.

## Timing
- **Reset:** all outputs 0 and FSM in IDLE. `mem_req` falls immediately on `rst_n` assertion, even mid-REQ; the transaction is abandoned.
- **Minimum access:** 3 cycles (IDLE issue, REQ with ack, DONE); `stall` high for 2 cycles.
- **General latency:** ack in the n-th REQ cycle gives `stall` high n+1 cycles, `done` in the cycle after ack.
- `mem_ack` is ignored outside REQ.
- **Timeout:** `TIMEOUT` REQ cycles without ack, `done` on the next cycle. An ack arriving on the same cycle as expiry takes priority (err 00).
- The error path in IDLE is 1 cycle with no stall.
- Counter width: $clog2(`TIMEOUT`+1); it saturates and never wraps.

## Test plan
- **LW, fast ack:** `addr`=0x100, `mem_ack` in first REQ cycle, `mem_rdata`=0xDEADBEEF → `mem_be`=1111, `mem_addr`=0x100, `stall` 2 cycles, `done` with `rdata`=0xDEADBEEF, err 00.
- **LB/LBU at 0x103:** `mem_rdata`=0x80123456 → LB `rdata`=0xFFFFFF80; LBU `rdata`=0x00000080. Ack delayed 4 cycles → `stall` 5 cycles.
- **SH at 0x202:** `wdata`=0x0000ABCD → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_addr`=0x200; SB at 0x201 → `mem_be`=0010.
- **Errors:**
  - LW at 0x102 → no `mem_req`, `done`+err 01, `stall`=0.
  - `func3`=011 load → err 10.
  - `rd_en`=`wr_en`=1 → err 10.
- **Timeout:** `TIMEOUT`=4, no ack → `mem_req` high 4 cycles, then `done`, err 11, `rdata`=0. Repeat with ack on 4th cycle → err 00.
- **Reset and back-to-back:**
  - Assert `rst_n`=0 in the 2nd REQ cycle → `mem_req`/`stall` 0 immediately, FSM IDLE after release.
  - LW then SW in consecutive instructions → two distinct transactions, one IDLE issue cycle between DONE and the second REQ.
